// File: rtl/threshold_neuron_seq_pkg.sv
// Shared FSM encoding and width helpers for the serial threshold neuron.
package threshold_neuron_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCUM  = 3'd1,
      ST_DECIDE = 3'd2,
      ST_OUTPUT = 3'd3,
      ST_UPDATE = 3'd4
   } state_e;

   // Headroom for N_IN full-precision products plus one sign bit.
   function automatic int acc_width(input int x_w, input int w_w, input int n_in);
      return x_w + w_w + $clog2(n_in) + 1;
   endfunction

   // Wide enough that w + x and w - x (including negating the most negative x) cannot wrap.
   function automatic int upd_width(input int x_w, input int w_w);
      return ((x_w > w_w) ? x_w : w_w) + 2;
   endfunction

endpackage

// File: rtl/threshold_neuron_seq_mac.sv
// Registered signed multiply-accumulate slice: clr zeroes the sum, en adds a*b.
module tlg_mac #(
   parameter int A_W   = 8,
   parameter int B_W   = 8,
   parameter int ACC_W = 18
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [A_W-1:0]   a,
   input  logic signed [B_W-1:0]   b,
   output logic signed [ACC_W-1:0] acc
);

   localparam int P_W = A_W + B_W;

   logic [P_W-1:0]          prod;
   logic signed [ACC_W-1:0] acc_d, acc_q;

   always_comb begin
      // Both operands sign-extended to the product width, so the low P_W bits are the signed product.
      prod  = {{B_W{a[A_W-1]}}, a} * {{A_W{b[B_W-1]}}, b};
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + {{(ACC_W-P_W){prod[P_W-1]}}, prod};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/threshold_neuron_seq.sv
// N-input threshold logic unit: serial signed MAC, threshold compare, optional perceptron update.
// in_valid/in_ready and out_valid/out_ready transfer on a cycle where both are high; valid holds until then.
module threshold_neuron_seq
   import threshold_neuron_seq_pkg::*;
#(
   parameter  int N_IN   = 4,
   parameter  int X_W    = 8,
   parameter  int W_W    = 8,
   parameter  int ETA_SH = 0,
   localparam int ACC_W  = acc_width(X_W, W_W, N_IN),
   localparam int IDX_W  = $clog2(N_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wload_en,
   input  logic [IDX_W-1:0]        wload_idx,
   input  logic signed [W_W-1:0]   wload_data,
   input  logic                    th_load,
   input  logic signed [ACC_W-1:0] th_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N_IN*X_W-1:0]     x_vec,
   input  logic                    train,
   input  logic                    target,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    F,
   output logic signed [ACC_W-1:0] acc_sum,
   output logic [15:0]             err_cnt,
   output logic [2:0]              dbg_state
);

   localparam int              UPD_W    = upd_width(X_W, W_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic signed [W_W-1:0]   w_q [N_IN];
   logic signed [W_W-1:0]   w_d [N_IN];
   logic signed [ACC_W-1:0] th_q, th_d, acc_sum_q, acc_sum_d, mac_acc;
   logic [N_IN*X_W-1:0]     x_q, x_d;
   logic                    train_q, train_d, target_q, target_d, f_q, f_d;
   logic [15:0]             err_q, err_d;

   logic                    accept, idx_last, upd_needed, mac_clr, mac_en;
   logic signed [X_W-1:0]   x_arr [N_IN];
   logic signed [X_W-1:0]   x_cur, x_step;
   logic signed [W_W-1:0]   w_cur, w_new;
   logic signed [UPD_W-1:0] w_ext, x_ext, upd_sum;

   function automatic logic signed [W_W-1:0] sat_w(input logic signed [UPD_W-1:0] v);
      if (v[UPD_W-1:W_W-1] == {(UPD_W-W_W+1){v[UPD_W-1]}}) begin
         return v[W_W-1:0];
      end else if (v[UPD_W-1]) begin
         return {1'b1, {(W_W-1){1'b0}}};
      end else begin
         return {1'b0, {(W_W-1){1'b1}}};
      end
   endfunction

   always_comb begin
      for (int i = 0; i < N_IN; i++) begin
         x_arr[i] = x_q[i*X_W +: X_W];
      end
   end

   assign accept     = in_valid & in_ready;
   assign idx_last   = (idx_q == IDX_LAST);
   assign upd_needed = train_q & (f_q != target_q);

   always_comb begin
      x_cur   = x_arr[idx_q];
      w_cur   = w_q[idx_q];
      x_step  = x_cur >>> ETA_SH;
      w_ext   = {{(UPD_W-W_W){w_cur[W_W-1]}}, w_cur};
      x_ext   = {{(UPD_W-X_W){x_step[X_W-1]}}, x_step};
      upd_sum = target_q ? (w_ext + x_ext) : (w_ext - x_ext);
      w_new   = sat_w(upd_sum);
   end

   tlg_mac #(
      .A_W   (W_W),
      .B_W   (X_W),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .a   (w_cur),
      .b   (x_cur),
      .acc (mac_acc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept) state_d = ST_ACCUM;
         ST_ACCUM:  if (idx_last) state_d = ST_DECIDE;
         ST_DECIDE: state_d = ST_OUTPUT;
         ST_OUTPUT: if (out_ready) state_d = upd_needed ? ST_UPDATE : ST_IDLE;
         ST_UPDATE: if (idx_last) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Register loads win over a new transaction, so in_ready drops while either load is asserted.
   always_comb begin
      in_ready  = (state_q == ST_IDLE) & ~wload_en & ~th_load & ~rst;
      out_valid = (state_q == ST_OUTPUT);
      dbg_state = state_q;
   end

   always_comb begin
      idx_d     = idx_q;
      x_d       = x_q;
      train_d   = train_q;
      target_d  = target_q;
      th_d      = th_q;
      f_d       = f_q;
      acc_sum_d = acc_sum_q;
      err_d     = err_q;
      w_d       = w_q;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wload_en && (32'(wload_idx) < N_IN)) w_d[wload_idx] = wload_data;
            if (th_load) th_d = th_data;
            if (accept) begin
               x_d      = x_vec;
               train_d  = train;
               target_d = target;
               idx_d    = '0;
               mac_clr  = 1'b1;
            end
         end
         ST_ACCUM: begin
            mac_en = 1'b1;
            idx_d  = idx_last ? '0 : idx_q + IDX_W'(1);
         end
         ST_DECIDE: begin
            f_d       = (mac_acc >= th_q);
            acc_sum_d = mac_acc;
         end
         ST_OUTPUT: begin
            if (out_ready && upd_needed && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
            idx_d = '0;
         end
         ST_UPDATE: begin
            w_d[idx_q] = w_new;
            idx_d      = idx_last ? '0 : idx_q + IDX_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q     <= '0;
         x_q       <= '0;
         train_q   <= 1'b0;
         target_q  <= 1'b0;
         th_q      <= '0;
         f_q       <= 1'b0;
         acc_sum_q <= '0;
         err_q     <= '0;
         for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
      end else begin
         idx_q     <= idx_d;
         x_q       <= x_d;
         train_q   <= train_d;
         target_q  <= target_d;
         th_q      <= th_d;
         f_q       <= f_d;
         acc_sum_q <= acc_sum_d;
         err_q     <= err_d;
         w_q       <= w_d;
      end
   end

   assign F       = f_q;
   assign acc_sum = acc_sum_q;
   assign err_cnt = err_q;

endmodule
